// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: walks the rows, samples the columns, rejects
// multi-key and non-digit presses, and debounces the digit over whole frames.
module keypad_scanner #(
    parameter int SCAN_DIV       = 256,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int NOKEY          = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_strobe
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [3:0]       NOKEY_C  = 4'(NOKEY);

    logic [2:0]       col_meta, col_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [1:0]       acc_cnt, acc_row, acc_col;
    logic [1:0]       merge_cnt, merge_row, merge_col;
    logic [3:0]       candidate;
    logic [CNT_W-1:0] stable_cnt;
    logic [3:0]       frame_code;
    logic             sample, frame_end;

    assign sample    = (div_cnt == DIV_LAST);
    assign frame_end = sample && (row_idx == 2'd3);

    // Fold this slot's closed switches into the frame accumulator.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        merge_cnt = acc_cnt;
        merge_row = acc_row;
        merge_col = acc_col;
        if (sample) begin
            for (int c = 0; c < 3; c++) begin
                if (!col_sync[c]) begin
                    if (merge_cnt != 2'd2)
                        merge_cnt = merge_cnt + 2'd1;
                    merge_row = row_idx;
                    merge_col = 2'(c);
                end
            end
        end
    end

    // Only a single closed digit switch yields a key; '*' and '#' do not.
    always_comb begin
        frame_code = NOKEY_C;
        if (merge_cnt == 2'd1) begin
            if (merge_row != 2'd3)
                frame_code = {2'b00, merge_row} * 4'd3 + {2'b00, merge_col} + 4'd1;
            else if (merge_col == 2'd1)
                frame_code = 4'd0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_meta   <= 3'b111;
            col_sync   <= 3'b111;
            div_cnt    <= '0;
            row_idx    <= 2'd0;
            row        <= 4'b1110;
            acc_cnt    <= 2'd0;
            acc_row    <= 2'd0;
            acc_col    <= 2'd0;
            candidate  <= NOKEY_C;
            stable_cnt <= '0;
            key        <= NOKEY_C;
            key_strobe <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register order-independent.
            col_meta <= col;
            col_sync <= col_meta;

            if (sample) begin
                div_cnt <= '0;
                row_idx <= row_idx + 2'd1;
                row     <= {row[2:0], row[3]};
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (frame_end) begin
                acc_cnt <= 2'd0;
                acc_row <= 2'd0;
                acc_col <= 2'd0;
                if (frame_code == candidate) begin
                    if (stable_cnt != CNT_MAX)
                        stable_cnt <= stable_cnt + 1'b1;
                end else begin
                    candidate  <= frame_code;
                    stable_cnt <= CNT_W'(1);
                end
            end else begin
                acc_cnt <= merge_cnt;
                acc_row <= merge_row;
                acc_col <= merge_col;
            end

            key_strobe <= 1'b0;
            if (stable_cnt == CNT_MAX && candidate != key) begin
                key        <= candidate;
                key_strobe <= (candidate != NOKEY_C);
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: switch-matrix model, frame-level reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_keypad_scanner;
    localparam int SD    = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4 * SD;
    localparam int NK    = 10;

    // Switch positions are r*3+c.
    localparam logic [11:0] K_NONE = 12'h000;
    localparam logic [11:0] K1     = 12'h001;
    localparam logic [11:0] K2     = 12'h002;
    localparam logic [11:0] K5     = 12'h010;
    localparam logic [11:0] K6     = 12'h020;
    localparam logic [11:0] K7     = 12'h040;
    localparam logic [11:0] KSTAR  = 12'h200;
    localparam logic [11:0] K0     = 12'h400;

    logic        clock, reset;
    logic [2:0]  col;
    logic [3:0]  row, key;
    logic        key_strobe;
    logic [11:0] pressed;

    int errors = 0;
    int checks = 0;

    int t, m_key, m_strobe, m_cand, m_run, m_pend;
    int dut_strobes, strobe_edge;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .NOKEY(NK)) dut (
        .clock(clock), .reset(reset), .col(col),
        .row(row), .key(key), .key_strobe(key_strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        col = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!row[r] && pressed[r*3+c])
                    col[c] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    // Key value a frame reports for a given set of closed switches.
    function automatic int model_code(input logic [11:0] p);
        int n = 0;
        int pos = 0;
        for (int i = 0; i < 12; i++)
            if (p[i]) begin
                n++;
                pos = i;
            end
        if (n != 1)   return NK;
        if (pos < 9)  return pos + 1;
        if (pos == 10) return 0;
        return NK;
    endfunction

    // Reference model and per-cycle compare, evaluated on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                t = 0; m_key = NK; m_strobe = 0; m_cand = NK; m_run = 0; m_pend = 0;
                dut_strobes = 0; strobe_edge = -1;
            end else begin
                m_strobe = 0;
                if (m_pend != 0) begin
                    m_key    = m_cand;
                    m_strobe = (m_cand != NK) ? 1 : 0;
                    m_pend   = 0;
                end
                if (t % FRAME == FRAME - 1) begin
                    if (model_code(pressed) == m_cand) m_run++;
                    else begin
                        m_cand = model_code(pressed);
                        m_run  = 1;
                    end
                    m_pend = (m_run >= DB && m_cand != m_key) ? 1 : 0;
                end
                t++;
                if (key_strobe) begin
                    dut_strobes++;
                    strobe_edge = t - 1;
                end
            end
            check("key", int'(key), m_key);
            check("key_strobe", int'(key_strobe), m_strobe);
            check("row", int'(row), int'(4'b1111 ^ (4'b0001 << ((t / SD) % 4))));
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic frames(input logic [11:0] pat, input int n);
        pressed = pat;
        repeat (n * FRAME) @(negedge clock);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        pressed = K_NONE;
        do_reset();
        check("reset_key", int'(key), NK);
        check("reset_row", int'(row), 4'b1110);
        check("reset_strobe", int'(key_strobe), 0);

        frames(K_NONE, 2);
        check("idle_key", int'(key), NK);
        check("idle_strobes", dut_strobes, 0);

        do_reset();
        frames(K5, 6);
        check("hold5_key", int'(key), 5);
        check("hold5_strobe_edge", strobe_edge, 48);
        check("hold5_strobes", dut_strobes, 1);
        frames(K_NONE, 4);
        check("release5_key", int'(key), NK);
        check("release5_strobes", dut_strobes, 1);

        do_reset();
        frames(K5, 1);
        frames(K_NONE, 1);
        frames(K5, 4);
        check("bounce5_key", int'(key), 5);
        check("bounce5_strobe_edge", strobe_edge, 80);
        check("bounce5_strobes", dut_strobes, 1);

        do_reset();
        frames(K1 | K2, 6);
        check("multi_key", int'(key), NK);
        check("multi_strobes", dut_strobes, 0);
        frames(K1, 4);
        check("single1_key", int'(key), 1);
        check("single1_strobes", dut_strobes, 1);

        do_reset();
        frames(KSTAR, 5);
        check("star_key", int'(key), NK);
        check("star_strobes", dut_strobes, 0);
        frames(K0, 4);
        check("zero_key", int'(key), 0);
        check("zero_strobes", dut_strobes, 1);

        do_reset();
        frames(K5, 4);
        frames(K6, 4);
        check("five_six_key", int'(key), 6);
        check("five_six_strobes", dut_strobes, 2);

        do_reset();
        frames(K7, 2);
        do_reset();
        check("rst7_key", int'(key), NK);
        frames(K7, 4);
        check("rst7_key_after", int'(key), 7);
        check("rst7_strobe_edge", strobe_edge, 48);
        check("rst7_strobes", dut_strobes, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
